operand_fetch: RTL

- Sequencer downstream of the 8:1 byte mux (mux_eight) in the MPU datapath.
- Accepts a two-operand read request (two 3-bit register indices) over a valid/ready handshake.
- Drives the mux select over two consecutive cycles and captures the mux output each time.
- Presents the operand pair (op_a, op_b) to the ALU stage over a second valid/ready handshake.

---
 rtl/mpu_pkg.sv | 16 +
 rtl/mux_eight.sv | 35 +++
 rtl/operand_fetch.sv | 101 ++++++++++
 3 files changed

// File: rtl/mpu_pkg.sv
// Shared MPU datapath definitions: default widths and the operand-fetch state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mpu_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int SEL_W_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH_A = 2'd1,
        FETCH_B = 2'd2,
        DONE    = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/mux_eight.sv
// Combinational 8:1 byte mux feeding the operand fetch sequencer.
// Latency: 0 cycles, y follows s within the same cycle.
// Backpressure: none, pure combinational selection.
module mux_eight #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic [2:0]       s,
    output logic [WIDTH-1:0] y
);

    // Select one of the eight inputs by index.
    always_comb begin
        y = a;
        case (s)
            3'd0: y = a;
            3'd1: y = b;
            3'd2: y = c;
            3'd3: y = d;
            3'd4: y = e;
            3'd5: y = f;
            3'd6: y = g;
            3'd7: y = h;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// Two-operand fetch sequencer: steps the mux select through rs1 then rs2 and captures each byte.
// Latency: accept on edge k -> op_a at k+1, op_b and out_valid at k+2; one pair per 3 cycles max.
// Backpressure: holds operands in DONE while out_ready=0 and deasserts req_ready until released.
module operand_fetch
    import mpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int SEL_W = SEL_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_rs1,
    input  logic [SEL_W-1:0] req_rs2,
    output logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] mux_data,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    fetch_state_t     state_q;
    fetch_state_t     state_d;
    logic [SEL_W-1:0] rs2_q;
    logic             accept;

    assign accept = req_valid & req_ready;

    // State register; reset wins over everything and aborts any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the two fetch cycles never stall, only DONE waits on the consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FETCH_A;
                end
            end
            FETCH_A: state_d = FETCH_B;
            FETCH_B: state_d = DONE;
            DONE: begin
                if (out_ready) begin
                    state_d = accept ? FETCH_A : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; a new request can be taken in the same cycle the pair is consumed.
    always_comb begin
        req_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
        busy      = (state_q != IDLE);
    end

    // Select and capture registers; the mux is combinational so each capture uses the
    // select that was registered on the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel       <= '0;
            rs2_q     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                sel   <= req_rs1;
                rs2_q <= req_rs2;
            end
            case (state_q)
                FETCH_A: begin
                    op_a <= mux_data;
                    sel  <= rs2_q;
                end
                FETCH_B: begin
                    op_b      <= mux_data;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
